alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Issue stage directly upstream of the 16-bit structural ALU.
- Buffers operation requests from the decode side in a small FIFO and drives the ALU's combinational operand and opcode inputs from the FIFO head.
- Captures the ALU result into an output register, with tag, zero and negative flags, and hands it downstream with a valid/ready handshake.
- Turns the combinational ALU into a flow-controlled, registered execution stage.

Parameters:
DATA_W, 16, operand and result width; must match the ALU.
DEPTH, 4, FIFO entries; power of two, at least 2.
TAG_W, 4, width of the opaque request tag carried alongside each operation.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  queue can accept a request; equals !full.
in_a  input  DATA_W  operand A.
in_b  input  DATA_W  operand B.
in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT.
in_tag  input  TAG_W  request tag.
alu_a  output  DATA_W  to ALU inputA.
alu_b  output  DATA_W  to ALU inputB.
alu_op  output  3  to ALU opcode.
alu_result  input  DATA_W  from ALU result; combinational in alu_a, alu_b and alu_op.
out_valid  output  1  output register holds a result.
out_ready  input  1  downstream accepts.
out_result  output  DATA_W  registered result.
out_tag  output  TAG_W  tag of that result.
out_zero  output  1  out_result == 0.
out_neg  output  1  out_result[DATA_W-1], and only for ADD or SUB.
out_err  output  1  request carried an illegal opcode (110 or 111).

Behaviour:
- Reset, synchronous, takes priority over all other activity:
  - FIFO emptied; read and write pointers and count set to 0.
  - out_valid=0; out_result=0; out_tag=0; out_zero=0; out_neg=0; out_err=0.
  - Anything in flight is discarded; nothing is emitted afterwards.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH), with no combinational path from out_ready.
  - A push on a full FIFO is impossible, even in a cycle that also pops.
- ALU drive:
  - FIFO non-empty: alu_a, alu_b and alu_op come combinationally from the head entry.
  - FIFO empty: alu_a=0, alu_b=0, alu_op=000.
- Capture/pop condition: FIFO non-empty && (!out_valid || out_ready). When it holds, at the clock edge:
  - out_result <= alu_result. If the head opcode is 110 or 111, out_result <= 0 and out_err <= 1; otherwise out_err <= 0.
  - out_tag <= head tag.
  - out_zero <= (captured value == 0).
  - out_neg <= captured[DATA_W-1] && (op == 000 || op == 001).
  - out_valid <= 1.
  - Head popped.
- Drain: out_valid && out_ready with an empty FIFO sets out_valid <= 0. The out_* data fields hold their last values.
- Stall: out_valid && !out_ready holds all out_* fields stable. The FIFO keeps accepting until full.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty FIFO: the new entry is written and not popped in that cycle. Bypass is not permitted.
- Latency:
  - Request accepted at edge k; result valid after edge k+1, so out_valid is high in the cycle after k+1.
  - Throughput is 1 per cycle when out_ready is held high.
- Capacity with out_ready=0: DEPTH+1 requests (DEPTH in the FIFO plus one in the output register).
- Ordering: strictly FIFO. Tags are never reordered, modified or inspected.
- Pointers: log2(DEPTH) bits, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Arithmetic: the block performs no arithmetic on operands; flags are derived from the captured result only.

Test Plan:
- ADD with A=0x7FFF, B=0x0001, tag=3, out_ready=1 -> two edges later out_result=0x8000, out_neg=1, out_zero=0, out_err=0, out_tag=3.
- SUB with A=0x0005, B=0x0005 -> out_result=0x0000, out_zero=1, out_neg=0. Then XOR with A=0xFFFF, B=0x0F0F -> out_result=0xF0F0, out_neg=0 (logical op).
- Backpressure: hold out_ready=0 and offer 6 requests with tags 0..5 back-to-back -> tags 0..4 accepted, in_ready=0 from the cycle after the 5th acceptance, tag 5 held off. Raise out_ready -> tags 0,1,2,3,4,5 emerge in order, one per cycle, with no duplicates or gaps.
- Illegal opcode 3'b111 with A=0x1234, B=0x5678 -> out_result=0x0000, out_err=1, out_zero=1. The next legal AND of 0x00FF and 0x0F0F -> 0x000F with out_err=0.
- Continuous stream of 20 requests with in_valid=1 and out_ready=1 -> 20 results in 20 consecutive cycles after the first 2-edge latency, in_ready never low, pointers wrap correctly.
- Assert rst for one cycle while 3 entries are queued and out_valid=1 -> next cycle out_valid=0 and in_ready=1. No pre-reset tag appears afterwards.

Source files
------------

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: small FIFO of ALU requests feeding a combinational ALU,
// with the ALU result captured into a flow-controlled output register.
module alu_issue_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Request storage, one array per field.
  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic [2:0]        mem_op  [DEPTH];
  logic [TAG_W-1:0]  mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  logic [2:0]        head_op;
  logic [TAG_W-1:0]  head_tag;
  logic              head_illegal;
  logic [DATA_W-1:0] capture_value;

  assign empty    = (count_reg == '0);
  // in_ready depends only on the occupancy, never on out_ready.
  assign in_ready = (count_reg != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop needs a non-empty FIFO, so an entry written this cycle cannot bypass.
  assign pop      = !empty && (!out_valid || out_ready);

  assign head_a   = mem_a[rd_ptr_reg];
  assign head_b   = mem_b[rd_ptr_reg];
  assign head_op  = mem_op[rd_ptr_reg];
  assign head_tag = mem_tag[rd_ptr_reg];

  // ALU inputs are parked at zero / ADD while the queue is empty.
  assign alu_a  = empty ? '0 : head_a;
  assign alu_b  = empty ? '0 : head_b;
  assign alu_op = empty ? 3'b000 : head_op;

  assign head_illegal  = (head_op[2:1] == 2'b11);
  assign capture_value = head_illegal ? '0 : alu_result;

  // Write the incoming request into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_a[wr_ptr_reg]   <= in_a;
      mem_b[wr_ptr_reg]   <= in_b;
      mem_op[wr_ptr_reg]  <= in_op;
      mem_tag[wr_ptr_reg] <= in_tag;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Output register: capture the head result on pop, clear valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_err    <= 1'b0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= capture_value;
      out_tag    <= head_tag;
      out_zero   <= (capture_value == '0);
      out_neg    <= capture_value[DATA_W-1] && (head_op == 3'b000 || head_op == 3'b001);
      out_err    <= head_illegal;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural ALU attached.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_neg;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  tag;
    logic        z;
    logic        n;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   xfer_cyc[$];
  exp_t got;

  alu_issue_queue #(.DATA_W(16), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the structural ALU; illegal opcodes give junk the queue must hide.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~alu_a;
      default: alu_result = alu_a ^ 16'hDEAD;
    endcase
  end

  // Reference: what the downstream side must see for one request.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op, input logic [3:0] tag);
    exp_t r;
    int   v;
    r.e = 1'b0;
    case (op)
      3'd0: v = (int'(a) + int'(b)) % 65536;
      3'd1: v = (int'(a) - int'(b) + 65536) % 65536;
      3'd2: v = int'(a & b);
      3'd3: v = int'(a | b);
      3'd4: v = int'(a ^ b);
      3'd5: v = 65535 - int'(a);
      default: begin v = 0; r.e = 1'b1; end
    endcase
    r.res = v[15:0];
    r.tag = tag;
    r.z   = (v == 0);
    r.n   = (v >= 32768) && (op <= 3'd1);
    return r;
  endfunction

  // Monitor and scoreboard: inputs are stable at the falling edge, so a
  // handshake seen here is the one the next rising edge will perform.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        got = {out_result, out_tag, out_zero, out_neg, out_err};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got res=%h tag=%0d, required no output", out_result, out_tag);
        end else begin
          if (got !== sb[0]) begin
            errors++;
            $display("FAIL result: got res=%h tag=%0d z=%b n=%b e=%b, required res=%h tag=%0d z=%b n=%b e=%b",
                     out_result, out_tag, out_zero, out_neg, out_err,
                     sb[0].res, sb[0].tag, sb[0].z, sb[0].n, sb[0].e);
          end else begin
            $display("xfer cyc=%0d res=%h tag=%0d z=%b n=%b e=%b", cyc, out_result, out_tag, out_zero, out_neg, out_err);
          end
          void'(sb.pop_front());
          xfer_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_op, in_tag));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Offer one request and hold it until accepted (bounded).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input logic [3:0] tag);
    bit done = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", tag);
    end
  endtask

  // Wait until every expected result has left the DUT (bounded).
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) done = 1;
    end
    @(posedge clk); #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
  endtask

  // The last n transfers must sit on consecutive cycles.
  task automatic check_back_to_back(input string name, input int n);
    bit ok = (xfer_cyc.size() >= n);
    if (ok)
      for (int i = xfer_cyc.size() - n + 1; i < xfer_cyc.size(); i++)
        if (xfer_cyc[i] != xfer_cyc[i-1] + 1) ok = 0;
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_flags", 32'({out_tag, out_zero, out_neg, out_err}), 32'd0);
    check("rst_alu_drive", 32'({alu_a, alu_b, alu_op}), 32'd0);
    @(posedge clk); #1;

    // Directed: ADD overflow into sign bit, with latency check
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 3'b000, 4'd3);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("add_neg", 32'({out_result, out_neg, out_zero, out_err, out_tag}), {16'h0, 16'h8000, 1'b1, 1'b0, 1'b0, 4'd3});
    drain();

    // Directed: SUB to zero, XOR logical (no neg), illegal op, then legal AND
    send(16'h0005, 16'h0005, 3'b001, 4'd1);
    send(16'hFFFF, 16'h0F0F, 3'b100, 4'd2);
    send(16'h1234, 16'h5678, 3'b111, 4'd4);
    send(16'h00FF, 16'h0F0F, 3'b010, 4'd5);
    send(16'h1234, 16'h0000, 3'b110, 4'd6);
    send(16'hF00F, 16'h0000, 3'b101, 4'd7);
    drain();

    // Backpressure: DEPTH+1 capacity, then in-order release
    out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_valid = 1'b1; in_a = 16'(t * 3); in_b = 16'(t); in_op = 3'b000; in_tag = 4'(t);
      @(negedge clk);
      check("bp_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_tag = 4'd5; in_a = 16'h8000; in_b = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full", 32'(in_ready), 32'd0);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_tag_held", 32'(out_tag), 32'd0);
      @(posedge clk); #1;
    end
    n0 = xfer_cyc.size();
    out_ready = 1'b1;
    send(16'h8000, 16'h8000, 3'b000, 4'd5);
    drain();
    check("bp_count", 32'(xfer_cyc.size() - n0), 32'd6);
    check_back_to_back("bp_consecutive", 6);

    // Continuous stream of 20 random legal requests
    n0 = xfer_cyc.size();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
      in_op = 3'($urandom_range(0, 5)); in_tag = 4'(i);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", 32'(xfer_cyc.size() - n0), 32'd20);
    check_back_to_back("stream_consecutive", 20);

    // Random traffic with random backpressure and all opcodes
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_a = 16'($urandom); in_b = 16'($urandom);
      in_op = 3'($urandom_range(0, 7)); in_tag = 4'($urandom);
      if (($urandom & 3) == 0) in_b = in_a;
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with 3 queued and one held in the output register
    out_ready = 1'b0;
    for (int t = 8; t < 12; t++) send(16'(t), 16'd1, 3'b000, 4'(t));
    @(negedge clk);
    check("prerst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_valid", 32'(out_valid), 32'd0);
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_tag", 32'(out_tag), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("postrst_quiet", 32'(out_valid), 32'd0);
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
